// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
// The state encoding and the counter sizing rule are used by the top and by the testbench.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width that can hold indices 0..nibbles-1, never narrower than one bit.
  function automatic int cnt_width(input int nibbles);
    int w;
    w = 1;
    if (nibbles > 1) begin
      w = $clog2(nibbles);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand and result handshake bundle for nibble_serial_adder.
// The master side supplies operands and accepts results; the slave side is the adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid,
    input  in_ready,
    output a,
    output b,
    output cin,
    output op,
    input  res_valid,
    output res_ready,
    input  sum,
    input  cout,
    input  overflow
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
    input  cin,
    input  op,
    output res_valid,
    input  res_ready,
    output sum,
    output cout,
    output overflow
  );

endinterface

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Purely combinational 4-bit carry-lookahead slice.
// Also exposes the carry into bit 3 so the caller can derive signed overflow.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Flat lookahead equations: every carry depends only on g, p and ci.
  always_comb begin
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c;
    c3   = c[3];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder/subtractor that streams operands through one 4-bit CLA slice,
// least significant nibble first, with ready/valid on both operand and result sides.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_adder_if.slave  bus
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = cnt_width(NIBBLES);

  generate
    if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             cout_q;
  logic             overflow_q;
  logic             res_valid_q;

  logic [CNT_W+1:0] lsb;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_s;
  logic             slice_co;
  logic             slice_c3;
  logic             last;

  // Bit offset of the active nibble is simply counter * 4.
  assign lsb     = {cnt, 2'b00};
  assign slice_a = opa[lsb +: NIBBLE_W];
  assign slice_b = opb[lsb +: NIBBLE_W];
  assign last    = (cnt == CNT_W'(NIBBLES - 1));

  cla4_slice u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co),
    .c3 (slice_c3)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    bus.in_ready = 1'b0;
    if (state == IDLE) begin
      bus.in_ready = 1'b1;
    end else begin
      bus.in_ready = 1'b0;
    end
  end

  // Operand capture, per-nibble accumulation and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa         <= '0;
      opb         <= '0;
      sum_q       <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtract is A + ~B + 1, so cin is replaced by a forced 1.
            opa   <= bus.a;
            opb   <= bus.op ? ~bus.b : bus.b;
            carry <= bus.op ? 1'b1 : bus.cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_q[lsb +: NIBBLE_W] <= slice_s;
          carry                  <= slice_co;
          cnt                    <= cnt + CNT_W'(1);
          if (last) begin
            cout_q      <= slice_co;
            overflow_q  <= slice_co ^ slice_c3;
            res_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = overflow_q;
  assign bus.res_valid = res_valid_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an operand and return just after the accepting edge.
  task automatic start_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic o);
    int waited;
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = ci;
    bus.op       = o;
    bus.in_valid = 1'b1;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq({tag, "_ready_seen"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'h0000;
    bus.b        = 16'h0000;
    bus.cin      = 1'b0;
    bus.op       = 1'b0;
    check_eq({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
  endtask

  // Count edges until res_valid, checking in_ready stays low, then check the result.
  task automatic wait_result(input string tag, input logic [15:0] es, input logic ec,
                             input logic eo);
    int lat;
    int busy_bad;
    lat      = 0;
    busy_bad = 0;
    while (bus.res_valid !== 1'b1 && lat < 20) begin
      if (bus.in_ready !== 1'b0) busy_bad++;
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd4);
    check_eq({tag, "_busy_ready"}, 32'(busy_bad), 32'd0);
    check_eq({tag, "_sum"}, 32'(bus.sum), 32'(es));
    check_eq({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    check_eq({tag, "_ovf"}, 32'(bus.overflow), 32'(eo));
  endtask

  task automatic drain(input string tag);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 32'(bus.res_valid), 32'd0);
    check_eq({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic full_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic o, input logic [15:0] es,
                         input logic ec, input logic eo);
    start_op(tag, av, bv, ci, o);
    wait_result(tag, es, ec, eo);
    drain(tag);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = 16'h0000;
    bus.b         = 16'h0000;
    bus.cin       = 1'b0;
    bus.op        = 1'b0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("rst_sum", 32'(bus.sum), 32'd0);
    check_eq("rst_cout", 32'(bus.cout), 32'd0);
    check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    full_op("add_carry8",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    full_op("add_ripple",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    full_op("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    full_op("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    full_op("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Backpressure: result held while in_valid toggles with fresh operands.
    start_op("bp", 16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_result("bp", 16'h3333, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.a        = 16'hAAAA + 16'(i);
      bus.b        = 16'h5555;
      @(posedge clk); #1;
      check_eq("bp_hold_sum", 32'(bus.sum), 32'h3333);
      check_eq("bp_hold_valid", 32'(bus.res_valid), 32'd1);
      check_eq("bp_hold_ready", 32'(bus.in_ready), 32'd0);
      check_eq("bp_hold_cout", 32'(bus.cout), 32'd0);
    end
    bus.a         = 16'h0F0F;
    bus.b         = 16'h0101;
    bus.cin       = 1'b0;
    bus.op        = 1'b0;
    bus.in_valid  = 1'b1;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check_eq("bp_drain_valid", 32'(bus.res_valid), 32'd0);
    check_eq("bp_drain_idle", 32'(bus.in_ready), 32'd1);
    check_eq("bp_drain_sum_kept", 32'(bus.sum), 32'h3333);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_eq("bp_next_accept", 32'(bus.in_ready), 32'd0);
    wait_result("bp_next", 16'h1010, 1'b0, 1'b0);
    drain("bp_next");

    // Asynchronous abort after two RUN cycles.
    start_op("abort", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("abort_sum", 32'(bus.sum), 32'd0);
    check_eq("abort_valid", 32'(bus.res_valid), 32'd0);
    check_eq("abort_cout", 32'(bus.cout), 32'd0);
    check_eq("abort_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    full_op("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder/subtractor that streams operands through a single 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first.
- Sits directly upstream of the 4-bit CLA stage. It sequences operand nibbles into the slice and registers the slice's carry between cycles.
- Trades latency for area in datapaths that cannot afford a full-width CLA tree.
- Ready/valid handshake on both the operand side and the result side.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and ≥ 4; any other value is an elaboration error.
- NIBBLES, WIDTH/4, derived. Number of RUN cycles; not to be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept an operand; equals (state==IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used when op=0, ignored when op=1.
- op  input  1  0 = A+B+cin, 1 = A−B.
- res_valid  output  1  result valid.
- res_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH−1. For subtract, 1 = no borrow.
- overflow  output  1  two's-complement overflow.

Behaviour:
- State machine: IDLE, RUN, DONE.
  - Reset (async, immediate): state=IDLE, nibble counter=0, carry reg=0, sum=0, cout=0, overflow=0, res_valid=0. in_ready=1 while in reset.
- IDLE:
  - in_valid & in_ready at edge T → capture a into A register.
  - Capture B register as b if op=0, ~b if op=1.
  - Capture carry reg as cin if op=0, 1 if op=1.
  - Clear counter; go to RUN.
  - Operand inputs are don't-care after capture.
- RUN (one nibble per cycle):
  - Slice inputs: A[4k+3:4k], B[4k+3:4k], carry reg, where k=counter.
  - At each edge: write slice sum into sum[4k+3:4k]; carry reg ← slice carry; counter increments.
  - When k = NIBBLES−1:
    - cout ← slice carry.
    - overflow ← slice carry XOR slice internal carry into bit 3.
    - res_valid ← 1; go to DONE.
  - Latency: res_valid rises at edge T+NIBBLES; 4 cycles for WIDTH=16.
  - Partial sum bits are visible on sum during RUN, but are meaningful only when res_valid=1.
- DONE:
  - sum/cout/overflow/res_valid held stable until res_valid & res_ready.
  - At the handshake edge: res_valid ← 0; go to IDLE. sum/cout/overflow keep their last values.
  - in_ready=0 in RUN and DONE; in_valid is ignored there.
  - No same-cycle result drain + new accept; minimum issue interval is NIBBLES+2 cycles.
- res_ready asserted early (during IDLE/RUN) has no effect.
- rst asserted mid-RUN or in DONE aborts the operation; no result is produced. The next accepted operation behaves as from power-up.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - Carry chain crosses nibble boundaries only via the carry reg.
  - No combinational path from a/b/cin/op to any output.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - NIBBLE_W=4;
  - counter width = clog2(NIBBLES), minimum 1.
- One sub-module: cla4_slice. Purely combinational 4-bit CLA: inputs a[3:0], b[3:0], ci; outputs s[3:0], co, c3 (carry into bit 3, needed for overflow).
- Everything else stays in nibble_serial_adder.

Test Plan (WIDTH=16):
- Add 0x00FF + 0x0001, cin=0, op=0 → sum=0x0100, cout=0, overflow=0. res_valid rises exactly 4 edges after accept; in_ready=0 throughout.
- Add 0xFFFF + 0x0000, cin=1 → sum=0x0000, cout=1, overflow=0. Exercises full carry ripple across all nibble boundaries.
- Add 0x7FFF + 0x0001 → sum=0x8000, overflow=1, cout=0. Subtract 0x8000 − 0x0001 (cin=0 ignored) → sum=0x7FFF, overflow=1, cout=1.
- Subtract 0x0005 − 0x0007 → sum=0xFFFE, cout=0 (borrow), overflow=0.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid, and toggle in_valid with new operands → sum/cout/overflow stable, in_ready=0, no capture. res_ready=1 → IDLE next cycle, then the new operand is accepted.
- Assert rst asynchronously after 2 RUN cycles → all outputs 0 immediately, in_ready=1. A following 0x1234 + 0x4321 yields 0x5555, cout=0, 4 cycles after accept.
